led_shift_latch: RTL and testbench
==================================

LED_SHIFT_LATCH -- requirements
Module: led_shift_latch

Interface
REQ-001 Parameter WIDTH, default 8: bits per channel frame, legal range 2..32.
REQ-002 Parameter CHANNELS, default 4: number of parallel serial lanes, legal range 1..8.
REQ-003 Parameter LSB_FIRST, default 0: 0 = first received bit lands in MSB, 1 = first received bit lands in LSB.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 data  input  CHANNELS  serial bit per lane, sampled on clk when en is low.
REQ-007 en  input  1  shift enable, active-low.
REQ-008 dout  output  CHANNELS*WIDTH  latched parallel frames; lane k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-009 frame_done  output  1  one-cycle pulse; a complete frame was latched to dout.
REQ-010 frame_err  output  1  one-cycle pulse; a partial frame was aborted.
REQ-011 busy  output  1  high while a frame is partially received (state SHIFT).
REQ-012 frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-013 The block SHALL hold one shadow register of WIDTH bits per lane plus a bit counter of ceil(log2(WIDTH)) bits; dout SHALL change only on frame completion.
REQ-014 FSM states SHALL be IDLE (counter 0) and SHIFT (counter 1..WIDTH-1).
REQ-015 IDLE, en low: shift bit into each shadow, counter <= 1, go SHIFT.
REQ-016 IDLE, en high: hold all state; no pulses.
REQ-017 SHIFT, en low, counter < WIDTH-1: shift, counter increments.
REQ-018 SHIFT, en low, counter == WIDTH-1: shift final bit, copy all WIDTH bits (including this final bit) to dout on the same edge, frame_done high for the next cycle, frame_cnt increments, counter <= 0, go IDLE.
REQ-019 Back-to-back frames: en held low continuously SHALL start the next frame on the cycle after completion with no gap bit lost; frame_done pulses every WIDTH cycles.
REQ-020 SHIFT, en high: abort; shadows cleared, counter <= 0, go IDLE, frame_err high for one cycle, dout and frame_cnt unchanged.
REQ-021 Shift order, LSB_FIRST=0: shadow <= {shadow[WIDTH-2:0], bit}; LSB_FIRST=1: shadow <= {bit, shadow[WIDTH-1:1]}.
REQ-022 frame_cnt SHALL wrap 255 -> 0 with no flag.
REQ-023 frame_done and frame_err SHALL never be high in the same cycle.
REQ-024 busy SHALL be registered and equal (state == SHIFT).

Reset
REQ-025 reset low at a clock edge SHALL clear dout, shadows, counter, frame_cnt, frame_done, frame_err, busy to 0 and force IDLE, overriding en.
REQ-026 Reset mid-frame SHALL discard the partial frame without asserting frame_err.
REQ-027 First shift after reset release SHALL require en low on a clock edge with reset high.

Structure
REQ-028 Package led_shift_pkg SHALL hold the FSM state type (IDLE, SHIFT) and default constants for WIDTH, CHANNELS, LSB_FIRST.
REQ-029 One sub-module shift_lane (WIDTH, LSB_FIRST) SHALL implement a single lane shadow plus output register, instantiated CHANNELS times; FSM, counter and flags live in the top.
REQ-030 Parameter range violations SHALL be caught by an elaboration-time check.

Verification
REQ-031 WIDTH=8, CHANNELS=2, MSB-first: lane0 bits 1,0,1,0,0,1,0,1, lane1 bits 0,0,1,1,1,1,0,0, en low 8 cycles -> dout=0x3CA5, one frame_done, frame_cnt=1.
REQ-032 Same lane0 bits 1,0,0,0,0,0,0,0 with LSB_FIRST=0 -> lane0=0x80; with LSB_FIRST=1 -> lane0=0x01.
REQ-033 After dout=0x3CA5, en low 5 cycles then high -> frame_err one cycle, busy drops, dout still 0x3CA5, frame_cnt unchanged.
REQ-034 en low 16 continuous cycles -> two frame_done pulses exactly 8 cycles apart, frame_cnt +2, busy never low between frames except completion cycle.
REQ-035 reset low after 4 bits of a frame -> all outputs 0 next cycle, no frame_err; fresh 8-bit frame afterwards latches correctly.
REQ-036 Force 256 completed frames -> frame_cnt returns to 0, frame_done still pulses on the 256th.

Source files
------------

// File: rtl/led_shift_pkg.sv
// rtl/led_shift_pkg.sv - shared FSM state type and default parameters for led_shift_latch
package led_shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_LSB_FIRST = 0;

endpackage

// File: rtl/led_shift_latch_shift_lane.sv
// rtl/led_shift_latch_shift_lane.sv - one serial lane: shadow shift register plus parallel output register
module shift_lane #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             clear,
    input  logic             load,
    input  logic             sdata,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shifted;

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign shifted = {sdata, shadow[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {shadow[WIDTH-2:0], sdata};
        end
    endgenerate

    // load carries the final bit, so the output takes the shifted value, not the stale shadow
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow <= '0;
            q      <= '0;
        end else begin
            if (clear) begin
                shadow <= '0;
            end else if (shift) begin
                shadow <= shifted;
            end
            if (load) begin
                q <= shifted;
            end
        end
    end

endmodule

// File: rtl/led_shift_latch.sv
// rtl/led_shift_latch.sv - multi-lane serial-to-parallel frame latch with done/abort pulses
module led_shift_latch
    import led_shift_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int LSB_FIRST = DEF_LSB_FIRST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       data,
    input  logic                      en,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      busy,
    output logic [7:0]                frame_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("led_shift_latch: WIDTH must be in 2..32");
        end
        if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
            $error("led_shift_latch: CHANNELS must be in 1..8");
        end
        if (LSB_FIRST != 0 && LSB_FIRST != 1) begin : g_bad_order
            $error("led_shift_latch: LSB_FIRST must be 0 or 1");
        end
    endgenerate

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic          shift, clear, load, done_next, err_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        shift      = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!en) begin
                    shift      = 1'b1;
                    next_cnt   = CW'(1);
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    shift = 1'b1;
                    if (cnt == LAST) begin
                        load       = 1'b1;
                        done_next  = 1'b1;
                        next_cnt   = '0;
                        next_state = IDLE;
                    end else begin
                        next_cnt = cnt + CW'(1);
                    end
                end else begin
                    clear      = 1'b1;
                    err_next   = 1'b1;
                    next_cnt   = '0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            cnt        <= next_cnt;
            frame_done <= done_next;
            frame_err  <= err_next;
            busy       <= (next_state == SHIFT);
            if (load) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            shift_lane #(
                .WIDTH     (WIDTH),
                .LSB_FIRST (LSB_FIRST)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .shift (shift),
                .clear (clear),
                .load  (load),
                .sdata (data[k]),
                .q     (dout[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_led_shift_latch.sv
// tb/tb_led_shift_latch.sv - scoreboard bench for led_shift_latch, MSB-first and LSB-first instances side by side
module tb_led_shift_latch;

    localparam int W  = 8;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b1;
    logic [CH-1:0] data = '0;

    logic [CH*W-1:0] dout_m, dout_l;
    logic            done_m, done_l, err_m, err_l, busy_m, busy_l;
    logic [7:0]      cnt_m, cnt_l;

    always #5 clk = ~clk;

    led_shift_latch #(.WIDTH(W), .CHANNELS(CH), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .data(data), .en(en), .dout(dout_m),
        .frame_done(done_m), .frame_err(err_m), .busy(busy_m), .frame_cnt(cnt_m)
    );

    led_shift_latch #(.WIDTH(W), .CHANNELS(CH), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .data(data), .en(en), .dout(dout_l),
        .frame_done(done_l), .frame_err(err_l), .busy(busy_l), .frame_cnt(cnt_l)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: bits received so far per lane, completed-frame values, frame count
    logic        lane_bits[CH][$];
    logic [31:0] m_dout_m, m_dout_l;
    int          m_cnt  = 0;
    int          m_pend = 0;          // 0 none, 1 done, 2 err, for the edge about to happen

    // snapshot of the model as of the most recent clock edge, compared by the monitor
    logic [31:0] cur_dout_m = '0, cur_dout_l = '0;
    int          cur_cnt    = 0;
    logic        cur_busy   = 1'b0;
    int          sb[$];
    logic        mon_on = 1'b0;

    initial begin
        m_dout_m = '0;
        m_dout_l = '0;
    end

    task automatic model_edge(input logic r, input logic e, input logic [CH-1:0] d);
        int v_m, v_l;
        if (!r) begin
            for (int k = 0; k < CH; k++) lane_bits[k].delete();
            m_dout_m = '0;
            m_dout_l = '0;
            m_cnt    = 0;
        end else if (e) begin
            if (lane_bits[0].size() > 0) m_pend = 2;
            for (int k = 0; k < CH; k++) lane_bits[k].delete();
        end else begin
            for (int k = 0; k < CH; k++) lane_bits[k].push_back(d[k]);
            if (lane_bits[0].size() == W) begin
                for (int k = 0; k < CH; k++) begin
                    v_m = 0;
                    v_l = 0;
                    for (int i = 0; i < W; i++) begin
                        v_m = v_m * 2 + int'(lane_bits[k][i]);
                        v_l = v_l + (int'(lane_bits[k][i]) << i);
                    end
                    m_dout_m[k*W +: W] = W'(v_m);
                    m_dout_l[k*W +: W] = W'(v_l);
                    lane_bits[k].delete();
                end
                m_cnt  = (m_cnt + 1) % 256;
                m_pend = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [CH-1:0] d);
        @(posedge clk);
        #1;
        cur_dout_m = m_dout_m;
        cur_dout_l = m_dout_l;
        cur_cnt    = m_cnt;
        cur_busy   = (lane_bits[0].size() > 0);
        if (m_pend != 0) sb.push_back(m_pend);
        m_pend = 0;
        reset = r;
        en    = e;
        data  = d;
        model_edge(r, e, d);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            int exp_kind;
            logic [1:0] exp_flags;
            chk("busy_msb", 32'(busy_m), 32'(cur_busy));
            chk("busy_lsb", 32'(busy_l), 32'(cur_busy));
            chk("dout_msb", 32'(dout_m), cur_dout_m);
            chk("dout_lsb", 32'(dout_l), cur_dout_l);
            chk("cnt_msb", 32'(cnt_m), 32'(cur_cnt));
            chk("cnt_lsb", 32'(cnt_l), 32'(cur_cnt));
            exp_kind = (sb.size() > 0) ? sb.pop_front() : 0;
            exp_flags = (exp_kind == 1) ? 2'b10 : (exp_kind == 2) ? 2'b01 : 2'b00;
            chk("pulse_msb", 32'({done_m, err_m}), 32'(exp_flags));
            chk("pulse_lsb", 32'({done_l, err_l}), 32'(exp_flags));
        end
    end

    logic [W-1:0] l0_bits, l1_bits;
    logic [CH-1:0] d_rnd;

    initial begin
        step(1'b0, 1'b1, '0);
        mon_on = 1'b1;
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, '0);

        // known frame: lane0 10100101, lane1 00111100 sent first-bit-first
        l0_bits = 8'b10100101;
        l1_bits = 8'b00111100;
        for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b0, {l1_bits[i], l0_bits[i]});
        step(1'b1, 1'b1, '0);
        @(negedge clk);
        chk("known_frame_dout", 32'(dout_m), 32'h3CA5);
        chk("known_frame_cnt", 32'(cnt_m), 32'd1);

        // abort after 5 bits
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'($urandom));
        step(1'b1, 1'b1, '0);
        step(1'b1, 1'b1, '0);
        @(negedge clk);
        chk("abort_keeps_dout", 32'(dout_m), 32'h3CA5);
        chk("abort_keeps_cnt", 32'(cnt_m), 32'd1);

        // single leading one: MSB lands in bit 7 or bit 0 depending on order
        l0_bits = 8'b10000000;
        for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b0, {1'b0, l0_bits[i]});
        step(1'b1, 1'b1, '0);
        @(negedge clk);
        chk("order_msb_lane0", 32'(dout_m[7:0]), 32'h80);
        chk("order_lsb_lane0", 32'(dout_l[7:0]), 32'h01);

        // back-to-back frames with en held low
        for (int i = 0; i < 2 * W; i++) step(1'b1, 1'b0, 2'($urandom));
        step(1'b1, 1'b1, '0);

        // reset after 4 bits, then a fresh frame
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'($urandom));
        step(1'b0, 1'b0, 2'b11);
        step(1'b1, 1'b1, '0);
        for (int i = 0; i < W; i++) step(1'b1, 1'b0, 2'($urandom));
        step(1'b1, 1'b1, '0);

        // random traffic with occasional aborts and resets
        for (int i = 0; i < 400; i++) begin
            d_rnd = 2'($urandom);
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0), d_rnd);
        end

        // 256 frames from reset: counter wraps to 0
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < 256 * W; i++) step(1'b1, 1'b0, 2'($urandom));
        step(1'b1, 1'b1, '0);
        @(negedge clk);
        chk("wrap_cnt", 32'(cnt_m), 32'd0);

        step(1'b1, 1'b1, '0);
        mon_on = 1'b0;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
